// File: rtl/redmule_exp_packer_if.sv
// Minimal HWPE stream interface: one data beat with byte strobes and a
// valid/ready handshake. A beat transfers on a rising edge with valid && ready.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/redmule_exp_packer.sv
// Exponent packer: packs one exponent per cycle, LSB lane first, into BEAT_WIDTH-bit
// stream beats. A flush closes a partial beat; a fill register plus an output register absorb stalls.
module redmule_exp_packer #(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned BEAT_WIDTH = 512,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [EXP_WIDTH-1:0]   exp_i,
    input  logic                   exp_valid_i,
    output logic                   exp_ready_o,
    input  logic                   flush_i,
    hwpe_stream_intf_stream.source stream_o,
    output logic [CNT_WIDTH-1:0]   beats_o,
    output logic                   idle_o
);
    localparam int unsigned EXPS_PER_BEAT = BEAT_WIDTH / EXP_WIDTH;
    localparam int unsigned LANE_W        = (EXPS_PER_BEAT > 1) ? $clog2(EXPS_PER_BEAT) : 1;
    localparam int unsigned STRB_W        = BEAT_WIDTH / 8;
    localparam int unsigned BYTES_PER_EXP = EXP_WIDTH / 8;
    localparam logic [LANE_W:0] FULL_CNT  = (LANE_W + 1)'(EXPS_PER_BEAT);

    logic [BEAT_WIDTH-1:0] fill_q, fill_d;
    logic [LANE_W-1:0]     cnt_q, cnt_d;
    logic                  fill_full_q, fill_full_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  exp_ready_q, exp_ready_d;
    logic [BEAT_WIDTH-1:0] out_data_q, out_data_d;
    logic [STRB_W-1:0]     out_strb_q, out_strb_d;
    logic                  out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0]  beats_q, beats_d;

    logic                  accept;
    logic                  slot_free;
    logic                  flush_req;
    logic [LANE_W:0]       n_fill;
    logic [BEAT_WIDTH-1:0] fill_wr;
    logic [STRB_W-1:0]     part_strb;
    logic                  move;
    logic [BEAT_WIDTH-1:0] move_data;
    logic [STRB_W-1:0]     move_strb;

    always_comb begin
        accept    = exp_valid_i && exp_ready_q;
        slot_free = !out_valid_q || stream_o.ready;
        flush_req = flush_i || flush_pend_q;
        n_fill    = {1'b0, cnt_q} + (LANE_W + 1)'(accept);

        fill_wr = fill_q;
        for (int l = 0; l < int'(EXPS_PER_BEAT); l++) begin
            if (accept && (cnt_q == LANE_W'(l))) begin
                fill_wr[l*EXP_WIDTH +: EXP_WIDTH] = exp_i;
            end
        end

        // Strobe covers exactly the lanes written so far; unused lanes stay zero.
        part_strb = '0;
        for (int s = 0; s < int'(STRB_W); s++) begin
            part_strb[s] = (s < int'(n_fill) * int'(BYTES_PER_EXP));
        end

        fill_d       = fill_q;
        cnt_d        = cnt_q;
        fill_full_d  = fill_full_q;
        flush_pend_d = flush_pend_q;
        out_data_d   = out_data_q;
        out_strb_d   = out_strb_q;
        out_valid_d  = out_valid_q && !stream_o.ready;
        beats_d      = beats_q + CNT_WIDTH'(out_valid_q && stream_o.ready);
        move         = 1'b0;
        move_data    = fill_wr;
        move_strb    = part_strb;

        if (fill_full_q) begin
            // A flush seen while a full beat waits resolves as that full beat.
            if (slot_free) begin
                move        = 1'b1;
                move_data   = fill_q;
                move_strb   = '1;
                fill_d      = '0;
                cnt_d       = '0;
                fill_full_d = 1'b0;
            end
        end else if ((n_fill == FULL_CNT) || (flush_req && (n_fill != '0))) begin
            if (slot_free) begin
                move         = 1'b1;
                fill_d       = '0;
                cnt_d        = '0;
                flush_pend_d = 1'b0;
            end else begin
                fill_d       = fill_wr;
                cnt_d        = n_fill[LANE_W-1:0];
                fill_full_d  = (n_fill == FULL_CNT);
                flush_pend_d = (n_fill != FULL_CNT);
            end
        end else begin
            fill_d       = fill_wr;
            cnt_d        = n_fill[LANE_W-1:0];
            flush_pend_d = 1'b0;
        end

        if (move) begin
            out_data_d  = move_data;
            out_strb_d  = move_strb;
            out_valid_d = 1'b1;
        end

        // Ready also drops for the cycle after any flush so a job boundary is never crossed.
        exp_ready_d = !fill_full_d && !flush_pend_d && !flush_i;

        if (clear_i) begin
            fill_d       = '0;
            cnt_d        = '0;
            fill_full_d  = 1'b0;
            flush_pend_d = 1'b0;
            exp_ready_d  = 1'b1;
            out_data_d   = '0;
            out_strb_d   = '0;
            out_valid_d  = 1'b0;
            beats_d      = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_q       <= '0;
            cnt_q        <= '0;
            fill_full_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            exp_ready_q  <= 1'b1;
            out_data_q   <= '0;
            out_strb_q   <= '0;
            out_valid_q  <= 1'b0;
            beats_q      <= '0;
        end else begin
            fill_q       <= fill_d;
            cnt_q        <= cnt_d;
            fill_full_q  <= fill_full_d;
            flush_pend_q <= flush_pend_d;
            exp_ready_q  <= exp_ready_d;
            out_data_q   <= out_data_d;
            out_strb_q   <= out_strb_d;
            out_valid_q  <= out_valid_d;
            beats_q      <= beats_d;
        end
    end

    assign stream_o.valid = out_valid_q;
    assign stream_o.data  = out_data_q;
    assign stream_o.strb  = out_strb_q;
    assign exp_ready_o    = exp_ready_q;
    assign beats_o        = beats_q;
    assign idle_o         = (cnt_q == '0) && !fill_full_q && !out_valid_q && !flush_pend_q;
endmodule

// File: tb/tb_redmule_exp_packer.sv
// Bench for redmule_exp_packer: 8-bit instance under random and directed traffic against
// a queue-based beat model, plus a directed 32-bit W-vector instance.
module tb_redmule_exp_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr = 1'b0;

  logic [7:0]  e8 = '0;
  logic        v8 = 1'b0;
  logic        f8 = 1'b0;
  logic        rdy8;
  logic [15:0] beats8;
  logic        idle8;

  logic [31:0] e32 = '0;
  logic        v32 = 1'b0;
  logic        f32 = 1'b0;
  logic        rdy32;
  logic [15:0] beats32;
  logic        idle32;

  int total = 0;
  int bad = 0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(512)) s8 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(512)) s32 ();

  redmule_exp_packer #(.EXP_WIDTH(8), .BEAT_WIDTH(512), .CNT_WIDTH(16)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .exp_i(e8), .exp_valid_i(v8),
    .exp_ready_o(rdy8), .flush_i(f8), .stream_o(s8), .beats_o(beats8), .idle_o(idle8)
  );

  redmule_exp_packer #(.EXP_WIDTH(32), .BEAT_WIDTH(512), .CNT_WIDTH(16)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .exp_i(e32), .exp_valid_i(v32),
    .exp_ready_o(rdy32), .flush_i(f32), .stream_o(s32), .beats_o(beats32), .idle_o(idle32)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp_v);
    end
  endtask

  // model: exponents of the open beat, and closed beats not yet handshaked
  logic [7:0]   cur[$];
  logic [511:0] exp_q[$];
  logic [63:0]  strb_q[$];
  logic [15:0]  hs_cnt = '0;
  bit prev_stall = 0, prev_free = 1, prev_closed = 0, prev_flush = 0, post_clear = 0;
  bit acc, closed;

  task automatic close_beat();
    logic [511:0] d;
    logic [63:0]  s;
    d = '0;
    s = '0;
    for (int i = 0; i < cur.size(); i++) begin
      d[i*8 +: 8] = cur[i];
      s[i] = 1'b1;
    end
    exp_q.push_back(d);
    strb_q.push_back(s);
    cur.delete();
  endtask

  // scoreboard: one compare per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n || clr) begin
      if (!rst_n) begin
        check("rst_valid", s8.valid, 0);
        check("rst_beats", beats8, 0);
      end
      cur.delete();
      exp_q.delete();
      strb_q.delete();
      hs_cnt = '0;
      prev_stall = 0;
      prev_free = 1;
      prev_closed = 0;
      prev_flush = 0;
      post_clear = clr;
    end else begin
      if (post_clear) begin
        check("clr_idle", idle8, 1);
        check("clr_valid", s8.valid, 0);
        post_clear = 0;
      end
      if (s8.valid) begin
        if (exp_q.size() == 0) check("spurious_valid", 1, 0);
        else begin
          check("beat_data", s8.data, exp_q[0]);
          check("beat_strb", s8.strb, strb_q[0]);
        end
      end
      if (prev_stall) check("valid_hold", s8.valid, 1);
      if (prev_closed && prev_free) check("beat_latency", s8.valid, 1);
      check("beats_cnt", beats8, hs_cnt);
      if (exp_q.size() >= 2) check("ready_when_full", rdy8, 0);
      if (exp_q.size() == 0 && !prev_flush) check("ready_idle", rdy8, 1);
      if (s8.valid && s8.ready) begin
        if (exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(strb_q.pop_front());
        end
        hs_cnt = hs_cnt + 16'd1;
      end
      prev_stall = s8.valid && !s8.ready;
      prev_free = !s8.valid || s8.ready;
      acc = v8 && rdy8;
      closed = 0;
      if (acc) begin
        cur.push_back(e8);
        if (cur.size() == 64) begin
          close_beat();
          closed = 1;
        end
      end
      if (f8 && cur.size() > 0) begin
        close_beat();
        closed = 1;
      end
      prev_closed = closed;
      prev_flush = f8;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    s8.ready = 1'b1;
    while (!idle8 && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("idle_timeout", 0, 1);
  endtask

  task automatic feed8(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      v8 = 1'b1;
      e8 = rnd ? 8'($urandom) : 8'(i);
      tick();
    end
    v8 = 1'b0;
  endtask

  int sent;
  int guard;

  initial begin
    s8.ready = 1'b1;
    s32.ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_valid", s8.valid, 0);
    check("reset_data", s8.data, 0);
    check("reset_strb", s8.strb, 0);
    check("reset_ready", rdy8, 1);
    check("reset_beats", beats8, 0);
    check("reset_idle", idle8, 1);

    // 0x00..0x3F back to back: one full beat
    for (int i = 0; i < 64; i++) begin
      v8 = 1'b1;
      e8 = 8'(i);
      check("a_ready", rdy8, 1);
      tick();
    end
    v8 = 1'b0;
    check("a_valid", s8.valid, 1);
    check("a_byte0", s8.data[7:0], 8'h00);
    check("a_byte1", s8.data[15:8], 8'h01);
    check("a_byte63", s8.data[511:504], 8'h3F);
    check("a_strb", s8.strb, {64{1'b1}});
    tick();
    check("a_beats", beats8, 1);

    // flush together with the 3rd accept
    for (int i = 0; i < 3; i++) begin
      v8 = 1'b1;
      e8 = 8'(8'h11 * (i + 1));
      f8 = (i == 2);
      tick();
    end
    v8 = 1'b0;
    f8 = 1'b0;
    check("p_valid", s8.valid, 1);
    check("p_data", s8.data, 512'h332211);
    check("p_strb", s8.strb, 64'h7);
    check("p_ready_low", rdy8, 0);
    tick();
    check("p_ready_back", rdy8, 1);
    check("p_beats", beats8, 2);

    // flush with nothing packed, then flush on exactly the 64th exponent
    f8 = 1'b1;
    tick();
    f8 = 1'b0;
    repeat (4) tick();
    check("e_no_beat", s8.valid, 0);
    check("e_beats", beats8, 2);
    for (int i = 0; i < 64; i++) begin
      v8 = 1'b1;
      e8 = 8'($urandom);
      f8 = (i == 63);
      tick();
    end
    v8 = 1'b0;
    f8 = 1'b0;
    wait_idle(50);
    repeat (3) tick();
    check("e_one_beat", beats8, 3);

    // output stalled while 130 exponents are offered
    s8.ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 200; c++) begin
      v8 = (sent < 130);
      e8 = 8'($urandom);
      acc = v8 && rdy8;
      tick();
      if (acc) sent++;
    end
    check("s_sent", sent, 128);
    check("s_ready_low", rdy8, 0);
    check("s_valid", s8.valid, 1);
    s8.ready = 1'b1;
    guard = 0;
    while (sent < 130 && guard < 50) begin
      v8 = 1'b1;
      e8 = 8'($urandom);
      acc = rdy8;
      tick();
      if (acc) sent++;
      guard++;
    end
    v8 = 1'b0;
    check("s_pending_taken", sent, 130);
    f8 = 1'b1;
    tick();
    f8 = 1'b0;
    wait_idle(100);
    check("s_beats", beats8, 6);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      s8.ready = (c % 1000 < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      v8 = ($urandom_range(0, 3) != 0);
      e8 = 8'($urandom);
      f8 = ($urandom_range(0, 39) == 0);
      tick();
    end
    v8 = 1'b0;
    f8 = 1'b1;
    tick();
    f8 = 1'b0;
    wait_idle(200);

    // clear while a beat is stalled in the output
    s8.ready = 1'b0;
    feed8(67, 1);
    check("c_stalled", s8.valid, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("c_valid", s8.valid, 0);
    check("c_idle", idle8, 1);
    check("c_beats", beats8, 0);
    check("c_ready", rdy8, 1);
    s8.ready = 1'b1;
    v8 = 1'b1;
    e8 = 8'h5A;
    f8 = 1'b1;
    tick();
    v8 = 1'b0;
    f8 = 1'b0;
    check("c_lane0_data", s8.data, 512'h5A);
    check("c_lane0_strb", s8.strb, 64'h1);
    wait_idle(20);

    // async reset mid-beat with output stalled
    s8.ready = 1'b0;
    feed8(66, 1);
    #2 rst_n = 1'b0;
    #1;
    check("r_valid", s8.valid, 0);
    check("r_data", s8.data, 0);
    check("r_beats", beats8, 0);
    check("r_idle", idle8, 1);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("r_quiet", s8.valid, 0);
    s8.ready = 1'b1;
    feed8(64, 1);
    wait_idle(50);
    check("model_drained", 32'(exp_q.size()), 0);

    // 32-bit W vectors: one full beat, then 5 lanes + flush
    for (int i = 0; i < 16; i++) begin
      v32 = 1'b1;
      e32 = 32'hA000_0000 + 32'(i);
      check("w_ready", rdy32, 1);
      tick();
    end
    v32 = 1'b0;
    check("w1_valid", s32.valid, 1);
    check("w1_lane0", s32.data[31:0], 32'hA000_0000);
    check("w1_lane15", s32.data[511:480], 32'hA000_000F);
    check("w1_strb", s32.strb, {64{1'b1}});
    for (int i = 0; i < 5; i++) begin
      v32 = 1'b1;
      e32 = 32'hA000_0010 + 32'(i);
      f32 = (i == 4);
      tick();
    end
    v32 = 1'b0;
    f32 = 1'b0;
    check("w2_valid", s32.valid, 1);
    check("w2_lane0", s32.data[31:0], 32'hA000_0010);
    check("w2_lane4", s32.data[159:128], 32'hA000_0014);
    check("w2_unused", s32.data[511:160], 0);
    check("w2_strb", s32.strb, 64'hF_FFFF);
    check("w2_ready_low", rdy32, 0);
    tick();
    check("w2_ready_back", rdy32, 1);
    check("w2_beats", beats32, 2);
    check("w2_idle", idle32, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/redmule_exp_packer.md
# redmule_exp_packer

Exponent packer: collects individual exponents produced one per cycle and packs them tightly, with no padding, into BEAT_WIDTH-bit beats on an HWPE stream source toward the streamer. It is the write-side counterpart of the exponent prefetch buffer. The lane layout matches what that buffer unpacks: 64×8-bit X exponents or 16×32-bit W vectors per 512-bit beat. A flush closes a partial beat at end of job, and output stalls are absorbed by a fill register plus an output register.

## Interface
- EXP_WIDTH, 8: exponent width in bits; multiple of 8, divides BEAT_WIDTH.
- BEAT_WIDTH, 512: output beat width.
- EXPS_PER_BEAT (derived): BEAT_WIDTH/EXP_WIDTH.
- CNT_WIDTH, 16: width of beat counter.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear to reset state.
- exp_i  in  EXP_WIDTH  exponent to pack.
- exp_valid_i  in  1  exp_i valid.
- exp_ready_o  out  1  packer accepts exp_i; registered.
- flush_i  in  1  request to emit current partial beat.
- stream_o  hwpe_stream_intf_stream.source  DATA_WIDTH=BEAT_WIDTH  packed beats (data, strb, valid, ready).
- beats_o  out  CNT_WIDTH  beats emitted (handshaked) since reset/clear; wraps.
- idle_o  out  1  fill empty, output empty, no flush pending.

## Operation
- State: fill register (BEAT_WIDTH), lane counter cnt_q (0..EXPS_PER_BEAT-1), fill_full_q, flush_pend_q, output register (data, strb, valid_q), beats_q.
- Accept = exp_valid_i && exp_ready_o. exp_ready_o = !fill_full_q && !flush_pend_q.
- On accept: fill[cnt_q*EXP_WIDTH +: EXP_WIDTH] <= exp_i. The first exponent goes to the LSB lane. cnt_q increments.
- Beat closes when the accept lands on lane EXPS_PER_BEAT-1, or when a flush is served with cnt>0.
- Output slot is free = !valid_q || stream_o.ready.
- Closing beat with slot free: move to output register with valid_q=1, strb=all ones for a full beat. Clear the fill register to zero and set cnt_q=0.
- Closing beat with slot busy: set fill_full_q=1 (exp_ready_o drops next cycle). Move the beat in the first cycle the slot frees, then clear fill_full_q.
- Flush: flush_i sets flush_pend_q. An exponent accepted in the same cycle as flush_i belongs to the flushed beat.
  - If cnt is 0 at service time: no beat is emitted and the pending flag clears.
  - Otherwise: emit the partial beat. Unused lanes are zero. strb has the low cnt*EXP_WIDTH/8 bits set, the rest 0. Clear flush_pend_q when the beat moves to the output register.
- Flush when the fill register is exactly full: handled as a normal full beat; no extra empty beat.
- beats_q increments on each stream_o valid&&ready.
- clear_i: all state returns to reset values and any pending output beat is dropped. Use only when the downstream consumer is idle.

## Timing
- Reset/clear values: stream_o.valid=0, data=0, strb=0, exp_ready_o=1, beats_o=0, idle_o=1.
- Latency: an exponent closing a beat at edge t makes stream_o.valid=1 at t+1 if the slot is free.
- A flush asserted at edge t with cnt>0 and the slot free gives valid at t+1, and exp_ready_o=0 during t+1.
- Throughput: 1 exponent/cycle sustained if the consumer takes each beat within EXPS_PER_BEAT cycles. No bubble between back-to-back beats.
- Stream rules: valid never drops without ready. data/strb stable while valid&&!ready. ready may depend on valid; valid never depends combinationally on ready.
- No combinational path from stream_o.ready to exp_ready_o.
- Async reset mid-beat: everything is discarded immediately and no stream valid is seen after reset release until new exponents are accepted.

## Test plan
- EXP_WIDTH=8, feed 0x00..0x3F on consecutive cycles with ready=1 -> one beat, byte i = i, strb all ones, valid 1 cycle after the last accept, beats_o=1.
- EXP_WIDTH=32, 16 values 0xA0000000+i, then 5 more + flush -> beat 1 full; beat 2 lanes 0..4 set, rest 0, strb=0xFFFFF, exp_ready_o low then high.
- ready=0 for 200 cycles while 130 exponents are offered -> beat 1 in output, beat 2 in fill, exp_ready_o=0 after exponent 128. Release ready -> beats in order, no loss, 2 pending exponents accepted.
- Flush with cnt=0, and flush after exactly 64 exponents -> no empty beat ever; beats_o counts only real beats.
- Flush in the same cycle as the 3rd exponent accept -> partial beat holds 3 lanes, strb=0x7.
- clear_i and async reset while valid&&!ready -> valid=0, idle_o=1, beats_o=0 next cycle; subsequent packing starts at lane 0.
